mac_seq: RTL and testbench
==========================

# mac_seq

Upstream sequencer for `mac_wrapper`: accepts a stream of 4-lane operand chunks over a valid/ready handshake and drives them into the MAC one chunk per cycle. It feeds the MAC's own output back as the partial sum, so a dot product of arbitrary length accumulates in place. On the final chunk it captures the completed psum into an output register and presents it over a second valid/ready handshake. It provides stall-safe accumulation around a MAC that registers its inputs every cycle and has no enable.

## Interface
- `bw`, 4, operand lane width
- `psum_bw`, 16, partial-sum width
- `clk`  in  1  clock, all state on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  chunk offered
- `in_ready`  out  1  chunk accepted when `in_valid && in_ready` at an edge
- `in_a`  in  [3:0][bw-1:0]  4 activation lanes
- `in_b`  in  [3:0][bw-1:0]  4 weight lanes
- `in_last`  in  1  chunk is the last of the vector
- `mac_a`  out  [3:0][bw-1:0]  to `mac_wrapper.a`
- `mac_b`  out  [3:0][bw-1:0]  to `mac_wrapper.b`
- `mac_c`  out  psum_bw  to `mac_wrapper.c`
- `mac_out`  in  psum_bw  from `mac_wrapper.out`
- `out_valid`  out  1  result held
- `out_ready`  in  1  result consumed when `out_valid && out_ready` at an edge
- `out_psum`  out  psum_bw  completed dot product

## Operation
- Define `fire = in_valid && in_ready`.
- `mac_a`/`mac_b` are combinational: `in_a`/`in_b` when `fire`, else all zeros (bubble, product 0).
- `mac_c` is combinational: 0 when `first`=1, else `mac_out`. Bubbles therefore hold the running psum unchanged.
- `first` is a register:
  - set by reset;
  - set on `fire && in_last`;
  - cleared on `fire && !in_last`.
- State machine, states `S_ACC` and `S_DONE`; reset state is `S_ACC`.
  - `S_ACC`: `fire && in_last` -> `S_DONE`; otherwise stay.
  - `S_DONE`: lasts exactly one cycle. At its closing edge, capture `mac_out` into `out_psum`, set `out_valid`, and return to `S_ACC`.
- `in_ready = (state == S_ACC) && !out_valid`. A new vector cannot start while a result is unconsumed.
- `out_valid` clears at an edge where `out_ready`=1. `out_psum` holds its value until the next capture.
- Arithmetic: the sequencer adds nothing itself. Wrap-around of the psum is the MAC's modulo-2^psum_bw behaviour. The sequencer does not saturate.
- Single-chunk vector (`in_last`=1 on the first chunk) is legal; result = that chunk's dot product.

## Timing
- Chunk accepted at edge E is registered by the MAC at E. `mac_out` reflects it during cycle E..E+1.
- Back-to-back chunks with no bubbles: N chunks need N cycles of `fire`.
- Last chunk at edge E: `state=S_DONE` during E..E+1; `out_valid`=1 after E+1. Latency from last accept to `out_valid` is 1 cycle.
- `out_ready` high in the first `out_valid` cycle: `out_valid` drops at the next edge, and `in_ready` rises in the same cycle.
- Reset values: `in_ready`=1, `out_valid`=0, `out_psum`=0, `mac_a`=0, `mac_b`=0, `mac_c`=0.
- Reset mid-vector: the partial sum is discarded. MAC pipeline registers are not reset; the first post-reset edge flushes them with zeros (`mac_c`=0).
- `in_valid` dropping mid-vector: bubbles are inserted indefinitely and the psum holds.
- `in_a`/`in_b`/`in_last` are don't-care when `in_valid`=0.

## Configuration
- Macro `MAC_SEQ_CNT_EN`.
  - Defined: adds output port `out_cnt [7:0]`, the number of chunks in the reported vector. It is captured alongside `out_psum`, saturates at 255, has reset value 0, and is held with `out_psum`. The internal counter clears on `fire && in_last`.
  - Undefined: no port and no counter logic; all other behaviour is identical.

## Test plan
- Reset: after `reset_n` deassert -> `in_ready`=1, `out_valid`=0, `out_psum`=0; one edge later `mac_out`=0.
- Three chunks, a={1,1,1,1}, b={2,2,2,2}, back-to-back, last on chunk 3, `out_ready`=1 -> `out_valid` 1 cycle after third accept, `out_psum`=24, `out_cnt`=3 if enabled.
- Same vector with `in_valid` low for 5 cycles between chunks 1 and 2 -> `out_psum`=24; `mac_a`/`mac_b`=0 during gap.
- Result backpressure: `out_ready`=0 for 4 cycles after result -> `in_ready`=0 and `out_psum` stable for those cycles; accepted on `out_ready`=1, then `in_ready`=1 next cycle.
- Single-chunk vector a={3,0,0,1}, b={1,5,5,2} -> `out_psum`=5.
- Reset asserted mid-vector after 2 chunks, then new 1-chunk vector a={1,0,0,0}, b={7,0,0,0} -> `out_psum`=7 (no stale partial sum).

Source files
------------

// File: rtl/mac_seq.sv
// mac_seq: chunk sequencer around an enable-less MAC, psum fed back in place.
// Optional chunk counter output enabled by `define MAC_SEQ_CNT_EN.
module mac_seq #(
  parameter int bw      = 4,
  parameter int psum_bw = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0][bw-1:0]    in_a,
  input  logic [3:0][bw-1:0]    in_b,
  input  logic                  in_last,
  output logic [3:0][bw-1:0]    mac_a,
  output logic [3:0][bw-1:0]    mac_b,
  output logic [psum_bw-1:0]    mac_c,
  input  logic [psum_bw-1:0]    mac_out,
  output logic                  out_valid,
  input  logic                  out_ready,
`ifdef MAC_SEQ_CNT_EN
  output logic [7:0]            out_cnt,
`endif
  output logic [psum_bw-1:0]    out_psum
);

  typedef enum logic {
    S_ACC,
    S_DONE
  } state_t;

  state_t state, state_nxt;
  logic   first;
  logic   fire;

  assign in_ready = (state == S_ACC) && !out_valid;
  assign fire     = in_valid && in_ready;

  // Bubbles feed zero products so the fed-back psum holds.
  assign mac_a = fire ? in_a : '0;
  assign mac_b = fire ? in_b : '0;
  assign mac_c = first ? '0 : mac_out;

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_ACC:  if (fire && in_last) state_nxt = S_DONE;
      S_DONE: state_nxt = S_ACC;
      default: state_nxt = S_ACC;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_ACC;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      first <= 1'b1;
    end else if (fire) begin
      first <= in_last;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_psum  <= '0;
    end else if (state == S_DONE) begin
      out_valid <= 1'b1;
      out_psum  <= mac_out;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MAC_SEQ_CNT_EN
  logic [7:0] cnt;
  logic [7:0] cnt_inc;
  logic [7:0] cnt_last;

  assign cnt_inc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

  // Count of the finished vector waits in cnt_last for the S_DONE capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      cnt_last <= '0;
      out_cnt  <= '0;
    end else begin
      if (fire) begin
        if (in_last) begin
          cnt      <= '0;
          cnt_last <= cnt_inc;
        end else begin
          cnt      <= cnt_inc;
        end
      end
      if (state == S_DONE) begin
        out_cnt <= cnt_last;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mac_seq.sv
// tb_mac_seq: table-driven vectors plus corner sequences for mac_seq.
// A behavioural MAC model closes the psum feedback loop.
module tb_mac_seq;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              in_valid;
  logic              in_ready;
  logic [3:0][3:0]   in_a;
  logic [3:0][3:0]   in_b;
  logic              in_last;
  logic [3:0][3:0]   mac_a;
  logic [3:0][3:0]   mac_b;
  logic [15:0]       mac_c;
  logic [15:0]       mac_out;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       out_psum;
`ifdef MAC_SEQ_CNT_EN
  logic [7:0]        out_cnt;
`endif

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] psum;
    logic [7:0]  cnt;
  } exp_t;

  exp_t q[$];

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        last;
    int          gap;
    logic [15:0] psum;
    logic [7:0]  cnt;
  } vec_t;

  vec_t tbl[9];

  mac_seq #(.bw(4), .psum_bw(16)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a(in_a),
    .in_b(in_b),
    .in_last(in_last),
    .mac_a(mac_a),
    .mac_b(mac_b),
    .mac_c(mac_c),
    .mac_out(mac_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
`ifdef MAC_SEQ_CNT_EN
    .out_cnt(out_cnt),
`endif
    .out_psum(out_psum)
  );

  always #5 clk = ~clk;

  // MAC model: unreset input registers, combinational sum
  logic [3:0][3:0] ra, rb;
  logic [15:0]     rc;

  always @(posedge clk) begin
    ra <= mac_a;
    rb <= mac_b;
    rc <= mac_c;
  end

  always_comb begin
    mac_out = rc;
    for (int i = 0; i < 4; i++)
      mac_out = mac_out + 16'(ra[i]) * 16'(rb[i]);
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got %0h expected none",
                 out_psum);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_psum", 32'(out_psum), 32'(e.psum));
`ifdef MAC_SEQ_CNT_EN
        chk("out_cnt", 32'(out_cnt), 32'(e.cnt));
`endif
      end
    end
  end

  function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b,
                              input logic last, input int gap,
                              input logic [15:0] p, input logic [7:0] c);
    vec_t v;
    v.a = a;
    v.b = b;
    v.last = last;
    v.gap = gap;
    v.psum = p;
    v.cnt = c;
    return v;
  endfunction

  // Call only #1 after a posedge; returns #1 after the accepting edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic last, input logic [15:0] p,
                      input logic [7:0] c);
    bit ok;
    exp_t e;
    ok = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_last = last;
    if (last) begin
      e.psum = p;
      e.cnt = c;
      q.push_back(e);
    end
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        ok = 1;
        break;
      end
    end
    in_valid = 1'b0;
    in_a = 16'hDEAD;
    in_b = 16'hBEEF;
    in_last = 1'b0;
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got no accept expected accept");
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_last = 1'b0;
    out_ready = 1'b1;

    tbl[0] = mk(16'h1111, 16'h2222, 0, 0, 0, 0);
    tbl[1] = mk(16'h1111, 16'h2222, 0, 0, 0, 0);
    tbl[2] = mk(16'h1111, 16'h2222, 1, 0, 24, 3);
    tbl[3] = mk(16'h3001, 16'h1552, 1, 0, 5, 1);
    tbl[4] = mk(16'h1111, 16'h2222, 0, 0, 0, 0);
    tbl[5] = mk(16'h1111, 16'h2222, 0, 5, 0, 0);
    tbl[6] = mk(16'h1111, 16'h2222, 1, 0, 24, 3);
    tbl[7] = mk(16'h1234, 16'h5678, 0, 0, 0, 0);
    tbl[8] = mk(16'h0009, 16'h0009, 1, 2, 151, 2);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_psum", 32'(out_psum), 0);
    chk("rst_mac_a", 32'(mac_a), 0);
    chk("rst_mac_b", 32'(mac_b), 0);
    chk("rst_mac_c", 32'(mac_c), 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_mac_out", 32'(mac_out), 0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      for (int g = 0; g < tbl[i].gap; g++) begin
        @(negedge clk);
        chk("gap_mac_a", 32'(mac_a), 0);
        chk("gap_mac_b", 32'(mac_b), 0);
        @(posedge clk);
        #1;
      end
      send(tbl[i].a, tbl[i].b, tbl[i].last, tbl[i].psum, tbl[i].cnt);
      if (tbl[i].last) begin
        @(negedge clk);
        chk("done_out_valid", 32'(out_valid), 0);
        chk("done_in_ready", 32'(in_ready), 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("lat_out_valid", 32'(out_valid), 1);
        @(posedge clk);
        #1;
      end
    end

    // result backpressure
    out_ready = 1'b0;
    send(16'h2000, 16'h3000, 1, 6, 1);
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_out_psum", 32'(out_psum), 6);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_rel_in_ready", 32'(in_ready), 1);
    chk("bp_rel_out_valid", 32'(out_valid), 0);
    @(posedge clk);
    #1;

    // psum wrap-around and count saturation: 300 chunks of 900
    for (int i = 0; i < 300; i++)
      send(16'hFFFF, 16'hFFFF, i == 299, 16'(300 * 900), 8'd255);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;

    // reset mid-vector discards the partial sum
    send(16'h1111, 16'h2222, 0, 0, 0);
    send(16'h1111, 16'h2222, 0, 0, 0);
    reset_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready", 32'(in_ready), 1);
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_out_psum", 32'(out_psum), 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    send(16'h1000, 16'h7000, 1, 7, 1);

    for (int k = 0; k < 100 && q.size() != 0; k++)
      @(negedge clk);
    chk("drain", 32'(q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
